// File: rtl/eth_frame_loop_tx_if.sv
// rtl/eth_frame_loop_tx_if.sv - frame, descriptor and MAC TX stream bundle
interface eth_frame_loop_tx_if;
  logic [7:0]  s_axis_frame_tdata;
  logic        s_axis_frame_tuser;
  logic        s_axis_frame_tlast;
  logic        s_axis_frame_tvalid;
  logic        s_axis_frame_tready;
  logic [31:0] s_axis_csum_tdata;
  logic        s_axis_csum_tvalid;
  logic        s_axis_csum_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  // Source side: drives both FIFO streams, receives the MAC stream
  modport master (
    output s_axis_frame_tdata, s_axis_frame_tuser, s_axis_frame_tlast, s_axis_frame_tvalid,
    input  s_axis_frame_tready,
    output s_axis_csum_tdata, s_axis_csum_tvalid,
    input  s_axis_csum_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );

  // TX stage side
  modport slave (
    input  s_axis_frame_tdata, s_axis_frame_tuser, s_axis_frame_tlast, s_axis_frame_tvalid,
    output s_axis_frame_tready,
    input  s_axis_csum_tdata, s_axis_csum_tvalid,
    output s_axis_csum_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );
endinterface

// File: rtl/eth_frame_loop_tx.sv
// rtl/eth_frame_loop_tx.sv - loopback TX stage: checksum patch and forward to MAC
module eth_frame_loop_tx #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cnt_clear,
  eth_frame_loop_tx_if.slave   bus,
  output logic [CNT_WIDTH-1:0] tx_frames,
  output logic [CNT_WIDTH-1:0] tx_aborted
);

  typedef enum logic {ST_WAIT_CSUM, ST_FORWARD} state_t;

  state_t      state;
  logic [15:0] byte_idx;
  logic [15:0] csum_val;
  logic [15:0] csum_off;
  logic        patch_en;
  logic        abort_seen;

  logic        fwd;
  logic        beat;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] csum_off_lo;

  assign fwd         = (state == ST_FORWARD);
  assign beat        = fwd && bus.s_axis_frame_tvalid && bus.m_axis_tready;
  assign frame_done  = beat && bus.s_axis_frame_tlast;
  assign frame_abort = abort_seen || bus.s_axis_frame_tuser;
  // Offset is always even, so +1 never carries out of 16 bits
  assign csum_off_lo = csum_off + 16'd1;

  // Pass-through handshake; nothing is presented to the MAC until a descriptor is held
  always_comb begin
    bus.s_axis_csum_tready  = !fwd;
    bus.s_axis_frame_tready = fwd && bus.m_axis_tready;
    bus.m_axis_tvalid       = fwd && bus.s_axis_frame_tvalid;
    bus.m_axis_tuser        = fwd && bus.s_axis_frame_tuser;
    bus.m_axis_tlast        = fwd && bus.s_axis_frame_tlast;
    bus.m_axis_tdata        = 8'h00;
    if (fwd) begin
      if (patch_en && byte_idx == csum_off)
        bus.m_axis_tdata = csum_val[15:8];
      else if (patch_en && byte_idx == csum_off_lo)
        bus.m_axis_tdata = csum_val[7:0];
      else
        bus.m_axis_tdata = bus.s_axis_frame_tdata;
    end
  end

  // Descriptor latch, byte position tracking and frame sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_WAIT_CSUM;
      byte_idx   <= 16'd0;
      csum_val   <= 16'd0;
      csum_off   <= 16'd0;
      patch_en   <= 1'b0;
      abort_seen <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_CSUM: begin
          if (bus.s_axis_csum_tvalid) begin
            csum_val   <= bus.s_axis_csum_tdata[31:16];
            csum_off   <= {bus.s_axis_csum_tdata[15:1], 1'b0};
            patch_en   <= bus.s_axis_csum_tdata[0];
            byte_idx   <= 16'd0;
            abort_seen <= 1'b0;
            state      <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (beat) begin
            if (byte_idx != 16'hFFFF)
              byte_idx <= byte_idx + 16'd1;
            abort_seen <= frame_abort;
            if (bus.s_axis_frame_tlast)
              state <= ST_WAIT_CSUM;
          end
        end
        default: state <= ST_WAIT_CSUM;
      endcase
    end
  end

  // Statistics: clear wins over a same-cycle frame completion; counters wrap
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      tx_frames  <= '0;
      tx_aborted <= '0;
    end else if (frame_done) begin
      if (frame_abort)
        tx_aborted <= tx_aborted + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      else
        tx_frames  <= tx_frames + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_eth_frame_loop_tx.sv
// tb/tb_eth_frame_loop_tx.sv - scoreboard bench for eth_frame_loop_tx
module tb_eth_frame_loop_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [31:0] tx_frames;
  logic [31:0] tx_aborted;
  logic        rand_ready = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [9:0]  sb[$];
  logic [7:0]  fd [0:255];
  logic        fu [0:255];

  eth_frame_loop_tx_if bus();

  eth_frame_loop_tx #(.CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clear  (cnt_clear),
    .bus        (bus.slave),
    .tx_frames  (tx_frames),
    .tx_aborted (tx_aborted)
  );

  always #5 clk = ~clk;

  // MAC ready: always ready, or a coin flip per cycle in stall mode
  always @(posedge clk) begin
    #1;
    bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Every output beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      if (sb.size() == 0) begin
        check("beat_without_expectation", 32'(sb.size()), 32'd1);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        check("out_beat", 32'({bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata}), 32'(e));
      end
    end
  end

  // Model of the patched frame: first n beats of a len-byte frame under descriptor d
  task automatic expect_frame(input int len, input logic [31:0] d, input int n);
    logic [15:0] off;
    logic [7:0]  b;
    off = {d[15:1], 1'b0};
    for (int i = 0; i < n; i++) begin
      b = fd[i];
      if (d[0] && 16'(i) == off) b = d[31:24];
      else if (d[0] && 16'(i) == off + 16'd1) b = d[23:16];
      sb.push_back({fu[i], (i == len - 1), b});
    end
  endtask

  task automatic send_desc(input logic [31:0] d);
    logic hs;
    hs = 1'b0;
    bus.s_axis_csum_tdata  = d;
    bus.s_axis_csum_tvalid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      hs = bus.s_axis_csum_tvalid && bus.s_axis_csum_tready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    check("desc_accept", 32'(hs), 32'd1);
    bus.s_axis_csum_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int stop_at, input bit clr_last);
    logic hs;
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) break;
      bus.s_axis_frame_tdata  = fd[i];
      bus.s_axis_frame_tuser  = fu[i];
      bus.s_axis_frame_tlast  = (i == len - 1);
      bus.s_axis_frame_tvalid = 1'b1;
      cnt_clear = clr_last && (i == len - 1);
      hs = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        hs = bus.s_axis_frame_tvalid && bus.s_axis_frame_tready;
        @(posedge clk);
        #1;
        if (hs) break;
      end
      if (!hs) check("byte_accept", 32'(hs), 32'd1);
    end
    bus.s_axis_frame_tvalid = 1'b0;
    bus.s_axis_frame_tlast  = 1'b0;
    bus.s_axis_frame_tuser  = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic fill(input int len, input int mode);
    for (int i = 0; i < 256; i++) begin
      fu[i] = 1'b0;
      case (mode)
        0: fd[i] = 8'hAA;
        1: fd[i] = 8'(i);
        default: fd[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  initial begin
    bus.s_axis_frame_tdata  = 8'h00;
    bus.s_axis_frame_tuser  = 1'b0;
    bus.s_axis_frame_tlast  = 1'b0;
    bus.s_axis_frame_tvalid = 1'b0;
    bus.s_axis_csum_tdata   = 32'h0;
    bus.s_axis_csum_tvalid  = 1'b0;
    fill(256, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst_m_tuser", 32'(bus.m_axis_tuser), 32'd0);
    check("rst_m_tlast", 32'(bus.m_axis_tlast), 32'd0);
    check("rst_frame_tready", 32'(bus.s_axis_frame_tready), 32'd0);
    check("rst_csum_tready", 32'(bus.s_axis_csum_tready), 32'd1);
    check("rst_tx_frames", tx_frames, 32'd0);
    check("rst_tx_aborted", tx_aborted, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Patched 64-byte frame of 0xAA, checksum at bytes 40/41
    fill(64, 0);
    expect_frame(64, 32'h1234_0029, 64);
    send_desc(32'h1234_0029);
    send_frame(64, -1, 1'b0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_tx_frames", tx_frames, 32'd1);

    // Descriptor with patch flag clear: frame unchanged
    fill(64, 1);
    expect_frame(64, 32'hBEEF_0028, 64);
    send_desc(32'hBEEF_0028);
    send_frame(64, -1, 1'b0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    check("t2_tx_frames", tx_frames, 32'd2);

    // Frame waiting without its descriptor is held off
    fill(10, 1);
    bus.s_axis_frame_tdata  = fd[0];
    bus.s_axis_frame_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("nodesc_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      check("nodesc_frame_tready", 32'(bus.s_axis_frame_tready), 32'd0);
    end
    @(posedge clk);
    #1;
    expect_frame(10, 32'h5555_0005, 10);
    send_desc(32'h5555_0005);
    check("desc_then_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    send_frame(10, -1, 1'b0);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    check("t3_tx_frames", tx_frames, 32'd3);

    // Single-byte aborted frame (overflow marker)
    fd[0] = 8'h00;
    fu[0] = 1'b1;
    expect_frame(1, 32'h0000_0000, 1);
    send_desc(32'h0000_0000);
    send_frame(1, -1, 1'b0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    check("t4_tx_aborted", tx_aborted, 32'd1);
    check("t4_tx_frames", tx_frames, 32'd3);

    // Abort flag on a middle byte still marks the whole frame aborted
    fill(5, 1);
    fu[1] = 1'b1;
    expect_frame(5, 32'h0000_0000, 5);
    send_desc(32'h0000_0000);
    send_frame(5, -1, 1'b0);
    check("t5_tx_aborted", tx_aborted, 32'd2);
    check("t5_tx_frames", tx_frames, 32'd3);

    // MAC back-pressure on patched frames, including patch at last byte
    rand_ready = 1'b1;
    fill(100, 2);
    expect_frame(100, 32'h5A6B_0011, 100);
    send_desc(32'h5A6B_0011);
    send_frame(100, -1, 1'b0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    fill(99, 2);
    expect_frame(99, 32'hCAFE_0063, 99);
    send_desc(32'hCAFE_0063);
    send_frame(99, -1, 1'b0);
    check("t7_sb_empty", 32'(sb.size()), 32'd0);
    check("t7_tx_frames", tx_frames, 32'd5);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Offset beyond the frame: forwarded unchanged
    fill(16, 1);
    expect_frame(16, 32'hFFFF_0081, 16);
    send_desc(32'hFFFF_0081);
    send_frame(16, -1, 1'b0);
    check("t8_sb_empty", 32'(sb.size()), 32'd0);
    check("t8_tx_frames", tx_frames, 32'd6);

    // Reset in the middle of a frame truncates it
    fill(64, 1);
    expect_frame(64, 32'h1111_0003, 30);
    send_desc(32'h1111_0003);
    send_frame(64, 30, 1'b0);
    check("t9_sb_empty", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.s_axis_frame_tdata  = fd[30];
    bus.s_axis_frame_tvalid = 1'b1;
    #1;
    check("midrst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("midrst_m_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("midrst_frame_tready", 32'(bus.s_axis_frame_tready), 32'd0);
    check("midrst_csum_tready", 32'(bus.s_axis_csum_tready), 32'd1);
    check("midrst_tx_frames", tx_frames, 32'd0);
    check("midrst_tx_aborted", tx_aborted, 32'd0);
    bus.s_axis_frame_tvalid = 1'b0;

    // Normal pair after reset
    fill(20, 2);
    expect_frame(20, 32'hA1B2_0007, 20);
    send_desc(32'hA1B2_0007);
    send_frame(20, -1, 1'b0);
    check("t10_sb_empty", 32'(sb.size()), 32'd0);
    check("t10_tx_frames", tx_frames, 32'd1);

    // Clear coinciding with a completing frame wins
    fill(8, 1);
    expect_frame(8, 32'h0000_0000, 8);
    send_desc(32'h0000_0000);
    send_frame(8, -1, 1'b1);
    check("clr_tx_frames", tx_frames, 32'd0);
    check("clr_tx_aborted", tx_aborted, 32'd0);

    // Counting resumes after the clear
    fill(3, 1);
    expect_frame(3, 32'h0000_0000, 3);
    send_desc(32'h0000_0000);
    send_frame(3, -1, 1'b0);
    check("t11_sb_empty", 32'(sb.size()), 32'd0);
    check("t11_tx_frames", tx_frames, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eth_frame_loop_tx.md
Name: eth_frame_loop_tx

Overview:
- Transmit-side stage directly downstream of the loopback receive stage.
- Consumes the buffered frame byte stream and its matching 32-bit checksum descriptor from two FIFOs.
- Patches the recomputed 16-bit transport checksum into the frame at the descriptor's byte offset when the frame was modified, then forwards the frame to the MAC TX AXI-Stream.
- Keeps frame/abort statistics counters.

Parameters:
- CNT_WIDTH, 32, width of the tx_frames and tx_aborted statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cnt_clear  in  1  synchronous clear of both statistics counters
- s_axis_frame_tdata  in  8  frame byte from frame FIFO
- s_axis_frame_tuser  in  1  error/abort flag on the byte
- s_axis_frame_tlast  in  1  last byte of frame
- s_axis_frame_tvalid  in  1  byte valid
- s_axis_frame_tready  out  1  byte accepted
- s_axis_csum_tdata  in  32  descriptor: [31:16] checksum, [15:1] word offset, [0] modified flag
- s_axis_csum_tvalid  in  1  descriptor valid
- s_axis_csum_tready  out  1  descriptor accepted
- m_axis_tdata  out  8  byte to MAC
- m_axis_tuser  out  1  abort flag to MAC
- m_axis_tlast  out  1  last byte
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  MAC ready
- tx_frames  out  CNT_WIDTH  frames completed without abort
- tx_aborted  out  CNT_WIDTH  frames completed with tuser seen on any byte

Behaviour:
- Reset: state ST_WAIT_CSUM; byte_idx=0; latched descriptor=0; abort_seen=0; tx_frames=0, tx_aborted=0.
- Reset output values: m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, s_axis_frame_tready=0, s_axis_csum_tready=1.
- Reset mid-frame: the output frame is truncated (tvalid drops, no tlast emitted). The MAC-side FIFO is reset alongside.

ST_WAIT_CSUM:
- s_axis_csum_tready=1; s_axis_frame_tready=0; m_axis_tvalid=0.
- On csum handshake:
  - latch csum_val=tdata[31:16]
  - latch csum_off={tdata[15:1],1'b0} (byte offset, always even)
  - latch patch_en=tdata[0]
  - byte_idx<=0, abort_seen<=0
  - go to ST_FORWARD
- A frame never starts before its descriptor. Frame bytes wait in the FIFO; this is valid for both descriptor-first and descriptor-last upstream modes.

ST_FORWARD:
- s_axis_csum_tready=0.
- Zero-latency pass-through:
  - m_axis_tvalid=s_axis_frame_tvalid
  - s_axis_frame_tready=m_axis_tready
  - tuser and tlast are passed unchanged
- m_axis_tdata selection:
  - csum_val[15:8] if patch_en and byte_idx==csum_off
  - csum_val[7:0] if patch_en and byte_idx==csum_off+1
  - otherwise s_axis_frame_tdata
- On each beat handshake:
  - byte_idx increments, saturating at 16'hFFFF
  - abort_seen |= tuser
- On handshake with tlast=1:
  - if (abort_seen|tuser), tx_aborted++; else tx_frames++
  - return to ST_WAIT_CSUM
- Boundary cases:
  - Offset beyond frame length: no patch, frame forwarded unchanged.
  - Offset equal to the last byte index: only the high byte is patched.
  - Offset arithmetic is 16-bit compare; csum_off+1 does not wrap (max even offset 0xFFFE, +1=0xFFFF).
  - Single-byte frame (tlast on byte 0) is legal.
  - tvalid held with tready low: output data and flags are stable (combinational from stable inputs).

Counters:
- Wrap on overflow.
- cnt_clear has priority over a same-cycle increment; the result is 0.

Test Plan:
- Descriptor 0x1234_0029 (offset 0x28, patch) then 64-byte frame of 0xAA -> bytes 40/41 out as 0x12/0x34, all others 0xAA; tlast on byte 63; tx_frames=1.
- Descriptor 0xBEEF_0028 (patch=0), 64-byte frame -> output identical to input; tx_frames increments.
- Frame bytes presented with no descriptor for 20 cycles -> m_axis_tvalid=0, s_axis_frame_tready=0. Descriptor then arrives -> frame starts the next cycle.
- Frame with tuser=1 on a 1-byte tlast beat (overflow marker 0x00) -> forwarded with tuser=1, tlast=1; tx_aborted=1, tx_frames unchanged.
- Random m_axis_tready deassertion (50%) during a patched 100-byte frame -> no byte lost or duplicated; patched bytes are correct. Descriptor offset 0x0062 (98) on a 99-byte frame -> only byte 98 patched.
- rst_n low for 1 cycle at byte 30 of 64 -> outputs reach reset values next cycle, counters=0. Next descriptor+frame pair processes normally. Then assert cnt_clear together with a completing tlast -> counters read 0.
